// File: rtl/press_event_pkg.sv
// ============================================================================
//  Module   : press_event_pkg
//  Purpose  : Shared state and counter-action encodings for press_event_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package press_event_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESS1    = 3'd1,
        ST_WAIT2     = 3'd2,
        ST_PRESS2    = 3'd3,
        ST_LONG_HOLD = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ACT_NONE = 2'd0,
        ACT_INC  = 2'd1,
        ACT_DEC  = 2'd2,
        ACT_CLR  = 2'd3
    } cnt_act_e;

endpackage

`default_nettype wire

// File: rtl/press_timer.sv
// ============================================================================
//  Module   : press_timer
//  Purpose  : Clock prescaler plus saturating tick counter, cleared on demand.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module press_timer #(
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned TICK_MAX = 4000,
    parameter int unsigned TICK_W   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    output logic [TICK_W-1:0] ticks,
    output logic              tick
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]     presc_q;
    logic [PW-1:0]     presc_d;
    logic [TICK_W-1:0] ticks_q;
    logic [TICK_W-1:0] ticks_d;

    assign tick  = (32'(presc_q) == TICK_DIV - 1);
    assign ticks = ticks_q;

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        ticks_d = ticks_q;
        if (tick && (32'(ticks_q) != TICK_MAX)) begin
            ticks_d = ticks_q + 1'b1;
        end
        // Clearing restarts the prescaler too, so no partial tick carries over.
        if (clear) begin
            presc_d = '0;
            ticks_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            ticks_q <= '0;
        end else begin
            presc_q <= presc_d;
            ticks_q <= ticks_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/press_event_ctrl.sv
// ============================================================================
//  Module   : press_event_ctrl
//  Purpose  : Classifies debounced presses as short/long/double, emits event
//             pulses and sequences a wrap-around mode counter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module press_event_ctrl
    import press_event_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 1000,
    parameter int unsigned SHORT_MAX  = 2000,
    parameter int unsigned LONG_MIN   = 4000,
    parameter int unsigned DOUBLE_GAP = 300,
    parameter int unsigned CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pb_down,
    input  logic             pb_up,
    input  logic             pb_state,
    output logic             evt_short,
    output logic             evt_long,
    output logic             evt_double,
    output logic             long_active,
    output logic [CNT_W-1:0] count,
    output logic             busy
);

    localparam int unsigned TICK_W = $clog2(LONG_MIN + 1);

    state_e            state_q;
    state_e            state_d;
    cnt_act_e          act;
    logic              evt_short_q, evt_short_d;
    logic              evt_long_q,  evt_long_d;
    logic              evt_double_q, evt_double_d;
    logic              long_active_q;
    logic              busy_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [TICK_W-1:0] w_ticks;
    logic [31:0]       w_ticks_ext;
    logic              w_tick_unused;
    logic              w_clear;
    logic              w_down;
    logic              w_rel;

    press_timer #(
        .TICK_DIV (TICK_DIV),
        .TICK_MAX (LONG_MIN),
        .TICK_W   (TICK_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .ticks (w_ticks),
        .tick  (w_tick_unused)
    );

    assign w_ticks_ext = 32'(w_ticks);
    // A simultaneous release wins; the coincident press strobe is dropped.
    assign w_down      = pb_down & ~pb_up;
    assign w_rel       = pb_up | pb_state;
    assign w_clear     = (state_d != state_q);

    always_comb begin
        state_d      = state_q;
        act          = ACT_NONE;
        evt_short_d  = 1'b0;
        evt_long_d   = 1'b0;
        evt_double_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_down) state_d = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (w_ticks_ext >= LONG_MIN) begin
                    evt_long_d = 1'b1;
                    act        = ACT_CLR;
                    state_d    = ST_LONG_HOLD;
                end else if (w_rel) begin
                    state_d = (w_ticks_ext <= SHORT_MAX) ? ST_WAIT2 : ST_IDLE;
                end
            end
            ST_WAIT2: begin
                if (w_down && (w_ticks_ext < DOUBLE_GAP)) begin
                    state_d = ST_PRESS2;
                end else if (w_ticks_ext >= DOUBLE_GAP) begin
                    evt_short_d = 1'b1;
                    act         = ACT_INC;
                    state_d     = ST_IDLE;
                end
            end
            ST_PRESS2: begin
                if (w_rel) begin
                    evt_double_d = 1'b1;
                    act          = ACT_DEC;
                    state_d      = ST_IDLE;
                end
            end
            ST_LONG_HOLD: begin
                if (w_rel) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case (act)
            ACT_INC:  count_d = count_q + 1'b1;
            ACT_DEC:  count_d = count_q - 1'b1;
            ACT_CLR:  count_d = '0;
            default:  count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            evt_short_q   <= 1'b0;
            evt_long_q    <= 1'b0;
            evt_double_q  <= 1'b0;
            long_active_q <= 1'b0;
            busy_q        <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            evt_short_q   <= evt_short_d;
            evt_long_q    <= evt_long_d;
            evt_double_q  <= evt_double_d;
            long_active_q <= (state_d == ST_LONG_HOLD);
            busy_q        <= (state_d != ST_IDLE);
            count_q       <= count_d;
        end
    end

    assign evt_short   = evt_short_q;
    assign evt_long    = evt_long_q;
    assign evt_double  = evt_double_q;
    assign long_active = long_active_q;
    assign busy        = busy_q;
    assign count       = count_q;

endmodule

`default_nettype wire

// File: tb/tb_press_event_ctrl.sv
// ============================================================================
//  Module   : tb_press_event_ctrl
//  Purpose  : Directed self-checking bench for press_event_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_press_event_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       pb_down;
    logic       pb_up;
    logic       pb_state;
    logic       evt_short;
    logic       evt_long;
    logic       evt_double;
    logic       long_active;
    logic [2:0] count;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_short  = 0;
    int n_long   = 0;
    int n_double = 0;
    int n_multi  = 0;

    press_event_ctrl #(
        .TICK_DIV   (4),
        .SHORT_MAX  (5),
        .LONG_MIN   (10),
        .DOUBLE_GAP (3),
        .CNT_W      (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pb_down     (pb_down),
        .pb_up       (pb_up),
        .pb_state    (pb_state),
        .evt_short   (evt_short),
        .evt_long    (evt_long),
        .evt_double  (evt_double),
        .long_active (long_active),
        .count       (count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one clock and tally any event pulses seen after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (evt_short)  n_short++;
        if (evt_long)   n_long++;
        if (evt_double) n_double++;
        if ((32'(evt_short) + 32'(evt_long) + 32'(evt_double)) > 1) n_multi++;
    endtask

    // Press strobe, hold for `hold` cycles after the press edge, then release.
    task automatic press(input int hold);
        pb_down  = 1'b1;
        pb_state = 1'b0;
        cyc();
        pb_down = 1'b0;
        repeat (hold) cyc();
        pb_up    = 1'b1;
        pb_state = 1'b1;
        cyc();
        pb_up = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int snap;
        logic got;

        rst      = 1'b1;
        pb_down  = 1'b0;
        pb_up    = 1'b0;
        pb_state = 1'b1;
        cyc();
        cyc();
        check("rst_count",  32'(count), 0);
        check("rst_short",  32'(evt_short), 0);
        check("rst_long",   32'(evt_long), 0);
        check("rst_double", 32'(evt_double), 0);
        check("rst_busy",   32'(busy), 0);
        check("rst_lact",   32'(long_active), 0);
        rst = 1'b0;
        cyc();
        cyc();

        // Short press: 3 ticks held, event 3 ticks + 1 cycle after release.
        press(12);
        check("short_wait_busy", 32'(busy), 1);
        repeat (12) cyc();
        check("short_not_early", 32'(n_short), 0);
        cyc();
        check("short_pulse", 32'(evt_short), 1);
        check("short_count", 32'(count), 1);
        cyc();
        check("short_single", 32'(evt_short), 0);
        check("short_idle",   32'(busy), 0);

        // Long press: evt_long 40 cycles + 1 after the press edge.
        pb_down  = 1'b1;
        pb_state = 1'b0;
        cyc();
        pb_down = 1'b0;
        repeat (40) cyc();
        check("long_not_early", 32'(evt_long), 0);
        check("long_lact_pre",  32'(long_active), 0);
        cyc();
        check("long_pulse", 32'(evt_long), 1);
        check("long_lact",  32'(long_active), 1);
        check("long_count", 32'(count), 0);
        cyc();
        check("long_single",   32'(evt_long), 0);
        check("long_lact_hold", 32'(long_active), 1);
        repeat (6) cyc();
        pb_up    = 1'b1;
        pb_state = 1'b1;
        cyc();
        pb_up = 1'b0;
        check("long_rel_lact", 32'(long_active), 0);
        check("long_rel_busy", 32'(busy), 0);
        repeat (20) cyc();
        check("long_n_long",  32'(n_long), 1);
        check("long_n_short", 32'(n_short), 1);
        check("long_n_dbl",   32'(n_double), 0);

        // Double press: 2-tick presses with a 1-tick gap.
        press(8);
        repeat (4) cyc();
        press(8);
        check("dbl_pulse", 32'(evt_double), 1);
        check("dbl_count", 32'(count), 7);
        check("dbl_busy",  32'(busy), 0);
        cyc();
        check("dbl_single", 32'(evt_double), 0);
        repeat (20) cyc();
        check("dbl_no_short", 32'(n_short), 1);
        check("dbl_n_dbl",    32'(n_double), 1);

        // Exactly SHORT_MAX ticks still counts as short: 7 -> 0.
        press(20);
        check("smax_wait_busy", 32'(busy), 1);
        repeat (16) cyc();
        check("smax_count", 32'(count), 0);
        check("smax_n_short", 32'(n_short), 2);

        // Mid-band releases at 6 and 7 ticks: no event.
        press(24);
        check("mid6_busy", 32'(busy), 0);
        press(28);
        check("mid7_busy", 32'(busy), 0);
        repeat (20) cyc();
        check("mid_count", 32'(count), 0);
        check("mid_events", 32'(n_short + n_long + n_double), 4);

        // Eight short presses (alternating 0- and 1-tick holds) wrap to 0.
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        check("rst2_count", 32'(count), 0);
        base = n_short;
        for (int i = 0; i < 8; i++) begin
            press((i % 2 == 1) ? 0 : 4);
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                cyc();
                if (evt_short) got = 1'b1;
            end
            check("wrap_evt", 32'(got), 1);
            if (i == 6) check("wrap_count7", 32'(count), 7);
        end
        check("wrap_count", 32'(count), 0);
        check("wrap_n_short", 32'(n_short - base), 8);

        // Reset in PRESS1 aborts the press.
        snap     = n_short + n_long + n_double;
        pb_down  = 1'b1;
        pb_state = 1'b0;
        cyc();
        pb_down = 1'b0;
        repeat (5) cyc();
        check("abort_busy_pre", 32'(busy), 1);
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        check("abort_busy_rst", 32'(busy), 0);
        repeat (3) cyc();
        pb_up    = 1'b1;
        pb_state = 1'b1;
        cyc();
        pb_up = 1'b0;
        repeat (20) cyc();
        check("abort_events", 32'(n_short + n_long + n_double), 32'(snap));
        check("abort_count",  32'(count), 0);
        check("abort_busy",   32'(busy), 0);
        check("one_evt_per_cycle", 32'(n_multi), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
